// File: rtl/qspi_wr_arbiter.sv
// qspi_wr_arbiter: tags QSPI write-burst words with their memory addresses, buffers them in a
// first-word-fall-through FIFO and shares the 16-bit memory write port with requester B using
// a watermark-aware round-robin. hClk domain, downstream of the QSPI synchronizer.
module qspi_wr_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned FIFO_AW   = 5,
  parameter int unsigned HI_WATER  = 24,
  parameter int unsigned MAX_Q_RUN = 8
) (
  input  logic              hClk,
  input  logic              hRst_n,
  input  logic              hdr_valid,
  input  logic              hdr_cmd,
  input  logic [31:0]       hdr_addr,
  input  logic [9:0]        hdr_len,
  input  logic              dat_valid,
  input  logic [15:0]       dat,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_data,
  output logic              b_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              ovf,
  output logic              trunc,
  output logic [7:0]        drop_cnt,
  input  logic              clr_status
);

  localparam int unsigned Depth  = 2 ** FIFO_AW;
  localparam int unsigned EntW   = ADDR_W + 16;
  localparam int unsigned LevelW = FIFO_AW + 1;
  localparam int unsigned QRunW  = $clog2(MAX_Q_RUN + 1);

  localparam logic [LevelW-1:0] LevelFull = LevelW'(Depth);
  localparam logic [LevelW-1:0] HiWater   = LevelW'(HI_WATER);
  localparam logic [QRunW-1:0]  QRunMax   = QRunW'(MAX_Q_RUN);

  typedef enum logic [1:0] {StIdle, StWrQ, StWrB} arb_state_e;

  // Header address bits above ADDR_W are deliberately ignored.
  logic [31:0] unused_hdr_addr;
  assign unused_hdr_addr = hdr_addr;

  // ---------------------------------------------------------------------------------------------
  // Input side: burst tracking and address tagging
  // ---------------------------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_addr_q, wr_ptr_addr_d, cur_addr;
  logic [9:0]        in_left_q, in_left_d, cur_left;
  logic              hdr_wr, word_in, fifo_full, push, drop;
  logic              ovf_q, trunc_q;
  logic [7:0]        drop_cnt_q;

  // FIFO state
  logic [EntW-1:0]    fifo_mem [Depth];
  logic [FIFO_AW-1:0] wr_idx_q, rd_idx_q, rd_idx_nxt;
  logic [LevelW-1:0]  level_q, level_d, level_post;
  logic [EntW-1:0]    cand_entry;
  logic               pop;

  // Arbiter state
  arb_state_e        state_q, state_d;
  logic              last_grant_b_q, last_b_post;
  logic [QRunW-1:0]  q_run_q, q_run_post;
  logic              accept_q, accept_b, rearb, q_cand, b_cand, pick_q, pick_b;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  // A same-cycle header is applied before the data word, so the word sees the new burst.
  always_comb begin
    hdr_wr        = hdr_valid & ~hdr_cmd & (hdr_len != 10'd0);
    cur_left      = hdr_wr ? hdr_len : in_left_q;
    cur_addr      = hdr_wr ? hdr_addr[ADDR_W-1:0] : wr_ptr_addr_q;
    word_in       = dat_valid & (cur_left != 10'd0);
    fifo_full     = (level_q == LevelFull);
    push          = word_in & ~fifo_full;
    drop          = dat_valid & ~push;
    // Pointer and count advance even on overflow drops so later words keep correct addresses.
    in_left_d     = cur_left - {9'd0, word_in};
    wr_ptr_addr_d = cur_addr + ADDR_W'(word_in);
  end

  // Burst pointer and remaining-word count.
  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      wr_ptr_addr_q <= '0;
      in_left_q     <= '0;
    end else begin
      wr_ptr_addr_q <= wr_ptr_addr_d;
      in_left_q     <= in_left_d;
    end
  end

  // Sticky status; clear has priority over any same-cycle set or increment.
  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      ovf_q      <= 1'b0;
      trunc_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_status) begin
      ovf_q      <= 1'b0;
      trunc_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (word_in && fifo_full) begin
        ovf_q <= 1'b1;
      end
      if (hdr_wr && (in_left_q != 10'd0)) begin
        trunc_q <= 1'b1;
      end
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Tagged-word FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------------------------

  // Storage needs no reset; validity is tracked by the pointers and level.
  always_ff @(posedge hClk) begin
    if (push) begin
      fifo_mem[wr_idx_q] <= {cur_addr, dat};
    end
  end

  // Head selection: after a pop the next candidate is the entry behind the current head.
  always_comb begin
    rd_idx_nxt = rd_idx_q + 1'b1;
    cand_entry = pop ? fifo_mem[rd_idx_nxt] : fifo_mem[rd_idx_q];
    level_d    = level_q + LevelW'(push) - LevelW'(pop);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_idx_q <= wr_idx_q + 1'b1;
      end
      if (pop) begin
        rd_idx_q <= rd_idx_nxt;
      end
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------------------------

  // Acceptance and post-acceptance arbitration inputs. B's own accept cycle excludes B, since
  // its b_req is still the request being acknowledged.
  always_comb begin
    accept_q   = (state_q == StWrQ) & mem_ready;
    accept_b   = (state_q == StWrB) & mem_ready;
    pop        = accept_q;
    level_post = level_q - LevelW'(pop);
    q_cand     = (level_post != '0);
    b_cand     = b_req & ~accept_b;
    rearb      = (state_q == StIdle) | accept_q | accept_b;

    if (accept_b) begin
      last_b_post = 1'b1;
    end else if (accept_q) begin
      last_b_post = 1'b0;
    end else begin
      last_b_post = last_grant_b_q;
    end

    if (accept_b || !b_req) begin
      q_run_post = '0;
    end else if (accept_q && (q_run_q != QRunMax)) begin
      q_run_post = q_run_q + 1'b1;
    end else begin
      q_run_post = q_run_q;
    end

    pick_q = 1'b0;
    pick_b = 1'b0;
    if (rearb) begin
      if (q_cand && b_cand) begin
        if (q_run_post == QRunMax) begin
          pick_b = 1'b1;
        end else if (level_post >= HiWater) begin
          pick_q = 1'b1;
        end else if (last_b_post) begin
          pick_q = 1'b1;
        end else begin
          pick_b = 1'b1;
        end
      end else if (q_cand) begin
        pick_q = 1'b1;
      end else if (b_cand) begin
        pick_b = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: hold in WR_x until accepted, otherwise follow the arbitration pick.
  always_comb begin
    state_d = state_q;
    if (rearb) begin
      if (pick_q) begin
        state_d = StWrQ;
      end else if (pick_b) begin
        state_d = StWrB;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Output next-values: load the winner on grant, drop mem_we when nothing is left.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rearb) begin
      if (pick_q) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cand_entry[EntW-1:16];
        mem_wdata_d = cand_entry[15:0];
      end else if (pick_b) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = b_addr;
        mem_wdata_d = b_data;
      end else begin
        mem_we_d    = 1'b0;
      end
    end
  end

  // Registered write port and round-robin history.
  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      last_grant_b_q <= 1'b1;
      q_run_q        <= '0;
    end else begin
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      last_grant_b_q <= last_b_post;
      q_run_q        <= q_run_post;
    end
  end

  assign b_ack     = accept_b;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (level_q != '0) | mem_we_q | (in_left_q != 10'd0);
  assign ovf       = ovf_q;
  assign trunc     = trunc_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_qspi_wr_arbiter.sv
// Scoreboard bench for qspi_wr_arbiter: stimulus pushes expected writes, a monitor pops and
// compares every accepted memory write.
module tb_qspi_wr_arbiter;
  localparam int unsigned ADDR_W = 18;
  localparam logic [ADDR_W-1:0] BBase = 18'h3F000;

  logic              hClk, hRst_n;
  logic              hdr_valid, hdr_cmd;
  logic [31:0]       hdr_addr;
  logic [9:0]        hdr_len;
  logic              dat_valid;
  logic [15:0]       dat;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_data;
  logic              b_ack, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ready;
  logic              busy, ovf, trunc;
  logic [7:0]        drop_cnt;
  logic              clr_status;

  typedef struct packed {
    logic              is_b;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  b_target = 0;
  int  b_done   = 0;

  qspi_wr_arbiter #(
    .ADDR_W   (18),
    .FIFO_AW  (5),
    .HI_WATER (24),
    .MAX_Q_RUN(8)
  ) dut (
    .hClk      (hClk),
    .hRst_n    (hRst_n),
    .hdr_valid (hdr_valid),
    .hdr_cmd   (hdr_cmd),
    .hdr_addr  (hdr_addr),
    .hdr_len   (hdr_len),
    .dat_valid (dat_valid),
    .dat       (dat),
    .b_req     (b_req),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ack     (b_ack),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .ovf       (ovf),
    .trunc     (trunc),
    .drop_cnt  (drop_cnt),
    .clr_status(clr_status)
  );

  initial hClk = 1'b0;
  always #5 hClk = ~hClk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hClk);
    #1;
  endtask

  task automatic pulse_hdr(input logic cmd, input logic [31:0] a, input logic [9:0] l);
    hdr_valid = 1'b1;
    hdr_cmd   = cmd;
    hdr_addr  = a;
    hdr_len   = l;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic pulse_dat(input logic [15:0] d);
    dat_valid = 1'b1;
    dat       = d;
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic exp_wq(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic exp_wb(input int k);
    exp_q.push_back({1'b1, BBase + ADDR_W'(k), 16'hB000 + 16'(k)});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_breq(input string name);
    int n;
    n = 0;
    while (!b_req && n < 20) begin
      tick();
      n++;
    end
    check({name, "_breq"}, 32'(b_req), 32'd1);
  endtask

  // Monitor: every accepted write (and every b_ack) must match the head of the scoreboard.
  initial begin
    wr_t got, e;
    forever begin
      @(negedge hClk);
      if (hRst_n && ((mem_we && mem_ready) || b_ack)) begin
        got = {b_ack, mem_addr, mem_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got b=%0d addr=%0h data=%0h expected none",
                   got.is_b, got.addr, got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write_order: got b=%0d addr=%0h data=%0h expected b=%0d addr=%0h data=%0h",
                     got.is_b, got.addr, got.data, e.is_b, e.addr, e.data);
          end
        end
      end
    end
  end

  // Requester B: holds b_req until acked, then presents its next request while b_done < b_target.
  initial begin
    logic ack_seen;
    b_req  = 1'b0;
    b_addr = '0;
    b_data = '0;
    forever begin
      @(negedge hClk);
      ack_seen = b_req && b_ack;
      @(posedge hClk);
      #1;
      if (ack_seen) begin
        b_done++;
        b_req = 1'b0;
      end
      if (!b_req && b_done < b_target) begin
        b_req  = 1'b1;
        b_addr = BBase + ADDR_W'(b_done);
        b_data = 16'hB000 + 16'(b_done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hRst_n     = 1'b0;
    hdr_valid  = 1'b0;
    hdr_cmd    = 1'b0;
    hdr_addr   = '0;
    hdr_len    = '0;
    dat_valid  = 1'b0;
    dat        = '0;
    mem_ready  = 1'b0;
    clr_status = 1'b0;
    #12;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_status", {29'd0, ovf, trunc, b_ack}, 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    @(posedge hClk);
    #1;
    hRst_n = 1'b1;
    tick();

    // 1: simple burst, then a burst wrapping the 18-bit address space
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_wq(18'h100 + 18'(i), 16'hA1 + 16'(i));
    pulse_hdr(1'b0, 32'h100, 10'd4);
    check("t1_busy_hdr", 32'(busy), 1);
    for (int i = 0; i < 4; i++) pulse_dat(16'hA1 + 16'(i));
    wait_drain("t1");
    check("t1_drop_cnt", 32'(drop_cnt), 0);
    exp_wq(18'h3FFFF, 16'hC1);
    exp_wq(18'h00000, 16'hC2);
    pulse_hdr(1'b0, 32'hFFFF_FFFF, 10'd2);
    pulse_dat(16'hC1);
    pulse_dat(16'hC2);
    wait_drain("t1_wrap");

    // 2: overflow with memory stalled
    mem_ready = 1'b0;
    pulse_hdr(1'b0, 32'h2000, 10'd40);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) exp_wq(18'h2000 + 18'(i), 16'hD000 + 16'(i));
      pulse_dat(16'hD000 + 16'(i));
    end
    tick();
    check("t2_ovf", 32'(ovf), 1);
    check("t2_drop_cnt", 32'(drop_cnt), 8);
    check("t2_mem_we_held", 32'(mem_we), 1);
    mem_ready = 1'b1;
    wait_drain("t2");
    pulse_clr();
    check("t2_clr", {23'd0, ovf, drop_cnt}, 0);

    // 3: low level -> strict alternation Q,B,Q,B,...
    mem_ready = 1'b0;
    pulse_hdr(1'b0, 32'h400, 10'd10);
    for (int i = 0; i < 10; i++) begin
      exp_wq(18'h400 + 18'(i), 16'hE000 + 16'(i));
      if (i < 4) exp_wb(i);
    end
    for (int i = 0; i < 10; i++) pulse_dat(16'hE000 + 16'(i));
    b_target = 4;
    wait_breq("t3");
    mem_ready = 1'b1;
    wait_drain("t3");
    check("t3_b_done", 32'(b_done), 4);

    // 4: level above the watermark -> 8 Q, 1 B, 8 Q, 1 B
    mem_ready = 1'b0;
    pulse_hdr(1'b0, 32'h1000, 10'd50);
    for (int i = 0; i < 50; i++) begin
      exp_wq(18'h1000 + 18'(i), 16'hF000 + 16'(i));
      if (i == 7) exp_wb(4);
      if (i == 15) exp_wb(5);
    end
    for (int i = 0; i < 28; i++) pulse_dat(16'hF000 + 16'(i));
    b_target = 6;
    wait_breq("t4");
    mem_ready = 1'b1;
    for (int i = 28; i < 50; i++) pulse_dat(16'hF000 + 16'(i));
    wait_drain("t4");
    check("t4_b_done", 32'(b_done), 6);
    check("t4_ovf", 32'(ovf), 0);

    // 5: truncating header with a same-cycle data word
    pulse_clr();
    exp_wq(18'h300, 16'h11);
    exp_wq(18'h301, 16'h22);
    exp_wq(18'h200, 16'h55);
    pulse_hdr(1'b0, 32'h300, 10'd5);
    pulse_dat(16'h11);
    pulse_dat(16'h22);
    hdr_valid = 1'b1;
    hdr_cmd   = 1'b0;
    hdr_addr  = 32'h200;
    hdr_len   = 10'd1;
    dat_valid = 1'b1;
    dat       = 16'h55;
    tick();
    hdr_valid = 1'b0;
    dat_valid = 1'b0;
    check("t5_trunc", 32'(trunc), 1);
    check("t5_drop_cnt", 32'(drop_cnt), 0);
    wait_drain("t5");
    pulse_dat(16'h66);
    check("t5_extra_dropped", 32'(drop_cnt), 1);
    check("t5_ovf", 32'(ovf), 0);

    // 6: ignored headers, saturation, clear priority
    pulse_clr();
    pulse_hdr(1'b1, 32'h600, 10'd3);
    for (int i = 0; i < 3; i++) pulse_dat(16'h7000 + 16'(i));
    check("t6_read_drops", 32'(drop_cnt), 3);
    pulse_hdr(1'b0, 32'h700, 10'd0);
    pulse_dat(16'h7777);
    check("t6_len0_drop", 32'(drop_cnt), 4);
    clr_status = 1'b1;
    dat_valid  = 1'b1;
    tick();
    clr_status = 1'b0;
    dat_valid  = 1'b0;
    check("t6_clr_wins", 32'(drop_cnt), 0);
    for (int i = 0; i < 260; i++) pulse_dat(16'h1234);
    check("t6_saturate", 32'(drop_cnt), 255);
    check("t6_no_ovf", 32'(ovf), 0);
    pulse_clr();

    // 6b: asynchronous reset while a Q write is stalled
    mem_ready = 1'b0;
    pulse_hdr(1'b0, 32'h800, 10'd3);
    for (int i = 0; i < 3; i++) pulse_dat(16'h8000 + 16'(i));
    tick();
    check("t6_we_before_rst", 32'(mem_we), 1);
    #2;
    hRst_n = 1'b0;
    #1;
    check("t6_rst_mem_we", 32'(mem_we), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(posedge hClk);
    #1;
    hRst_n    = 1'b1;
    mem_ready = 1'b1;
    repeat (5) tick();
    check("t6_post_rst_idle", {30'd0, mem_we, busy}, 0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
